// File: rtl/dmem_responder_if.sv
// Request/response bus between a requester and the data-memory responder.
// One request in flight; the response is held until the requester takes it.
interface dmem_responder_if #(
    parameter int SIZE = 12
);
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      mem_ctrl;
    logic [SIZE-1:0] addr;
    logic [31:0]     wdata;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [31:0]     rdata;
    logic            rsp_err;

    modport master (
        output req_valid, mem_ctrl, addr, wdata, rsp_ready,
        input  req_ready, rsp_valid, rdata, rsp_err
    );

    modport slave (
        input  req_valid, mem_ctrl, addr, wdata, rsp_ready,
        output req_ready, rsp_valid, rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Byte-addressed 32-bit data memory answering one load/store at a time.
// IDLE accepts, ACCESS touches the RAM, RESP holds the result until taken.
module dmem_responder #(
    parameter int SIZE = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    dmem_responder_if.slave  bus
);
    localparam int DEPTH = 2 ** (SIZE - 2);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [2:0]      r_ctrl;
    logic [SIZE-1:0] r_addr;
    logic [31:0]     r_wdata;
    logic            r_misalign;

    logic            w_accept;
    logic            w_misalign;
    logic            w_is_store;
    logic            w_do_write;
    logic [3:0]      w_be;
    logic [31:0]     w_lane_data;
    logic [31:0]     w_rword;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [31:0]     w_load;

    assign bus.req_ready = rst_n && (r_state == IDLE);
    assign w_accept      = bus.req_valid && bus.req_ready;

    always_comb begin
        w_misalign = 1'b0;
        case (bus.mem_ctrl)
            3'b001, 3'b100, 3'b110: w_misalign = bus.addr[0];
            3'b010, 3'b111:         w_misalign = |bus.addr[1:0];
            default:                w_misalign = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ctrl     <= 3'b000;
            r_addr     <= '0;
            r_wdata    <= 32'h0;
            r_misalign <= 1'b0;
        end else if (w_accept) begin
            r_ctrl     <= bus.mem_ctrl;
            r_addr     <= bus.addr;
            r_wdata    <= bus.wdata;
            r_misalign <= w_misalign;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_next = ACCESS;
            ACCESS:  w_state_next = RESP;
            RESP:    if (bus.rsp_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Store lanes: data is replicated so each lane just picks its own byte.
    assign w_is_store = r_ctrl[2] && (r_ctrl[1] || r_ctrl[0]);
    assign w_do_write = rst_n && (r_state == ACCESS) && w_is_store && !r_misalign;

    always_comb begin
        w_be        = 4'b0000;
        w_lane_data = 32'h0;
        case (r_ctrl)
            3'b101: begin
                w_be        = 4'b0001 << r_addr[1:0];
                w_lane_data = {4{r_wdata[7:0]}};
            end
            3'b110: begin
                w_be        = r_addr[1] ? 4'b1100 : 4'b0011;
                w_lane_data = {2{r_wdata[15:0]}};
            end
            3'b111: begin
                w_be        = 4'b1111;
                w_lane_data = r_wdata;
            end
            default: begin
                w_be        = 4'b0000;
                w_lane_data = 32'h0;
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] r_mem [DEPTH];
            logic [7:0] r_rbyte;

            always_ff @(posedge clk) begin
                if (w_do_write && w_be[gi]) begin
                    r_mem[r_addr[SIZE-1:2]] <= w_lane_data[8*gi +: 8];
                end
                if (r_state == ACCESS) begin
                    r_rbyte <= r_mem[r_addr[SIZE-1:2]];
                end
            end

            assign w_rword[8*gi +: 8] = r_rbyte;
        end
    endgenerate

    assign w_byte = w_rword[{r_addr[1:0], 3'b000} +: 8];
    assign w_half = r_addr[1] ? w_rword[31:16] : w_rword[15:0];

    always_comb begin
        w_load = 32'h0;
        case (r_ctrl)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b010:  w_load = w_rword;
            3'b011:  w_load = {24'h0, w_byte};
            3'b100:  w_load = {16'h0, w_half};
            default: w_load = 32'h0;
        endcase
    end

    assign bus.rsp_valid = (r_state == RESP);
    assign bus.rsp_err   = (r_state == RESP) && r_misalign;
    assign bus.rdata     = ((r_state == RESP) && !r_misalign && !w_is_store) ? w_load : 32'h0;
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter SIZE, default 12: byte-address width; memory depth is 2^(SIZE-2) 32-bit words.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port req_valid  input  1  request present.
REQ-005 SHALL have port req_ready  output  1  responder can accept a request.
REQ-006 SHALL have port mem_ctrl  input  3  access type: 000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU, 101 SB, 110 SH, 111 SW.
REQ-007 SHALL have port addr  input  SIZE  byte address.
REQ-008 SHALL have port wdata  input  32  store data, low-justified; SB uses [7:0], SH uses [15:0].
REQ-009 SHALL have port rsp_valid  output  1  response present.
REQ-010 SHALL have port rsp_ready  input  1  requester accepts the response.
REQ-011 SHALL have port rdata  output  32  load result, extended to 32 bits.
REQ-012 SHALL have port rsp_err  output  1  misaligned access; no memory effect.

Function
REQ-013 SHALL implement FSM states IDLE, ACCESS and RESP, one request in flight at most.
REQ-014 SHALL drive req_ready=1 only in IDLE with rst_n high; req_ready=0 in ACCESS and RESP.
REQ-015 SHALL accept a request on an edge where req_valid and req_ready are both 1, capture mem_ctrl/addr/wdata, and move IDLE->ACCESS.
REQ-016 SHALL flag misalignment at capture: halfword ops with addr[0]=1, word ops with addr[1:0]!=0; byte ops never misalign.
REQ-017 SHALL, in ACCESS, perform a synchronous read of word addr[SIZE-1:2] for loads, or a byte-enabled write for aligned stores, then move ACCESS->RESP.
REQ-018 SHALL write stores by lane: SB writes wdata[7:0] to lane addr[1:0]; SH writes wdata[15:0] to lanes {addr[1],0} and {addr[1],1}; SW writes all four lanes; other lanes unchanged.
REQ-019 SHALL commit a store on the ACCESS->RESP edge, so a load accepted after it returns the new data.
REQ-020 SHALL form load data from the selected lane(s): LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word.
REQ-021 SHALL present rdata=0, rsp_err=0 for completed stores, and rdata=0, rsp_err=1 for misaligned requests, with no memory write.
REQ-022 SHALL assert rsp_valid in RESP exactly 2 cycles after the accepting edge and hold rsp_valid, rdata and rsp_err stable until rsp_ready=1.
REQ-023 SHALL move RESP->IDLE on the edge where rsp_ready=1; req_ready is 1 on the following cycle, with no back-to-back bypass.
REQ-024 SHALL ignore req_valid, addr, wdata and mem_ctrl changes while not in IDLE.

Reset
REQ-025 SHALL, on any edge with rst_n=0, enter IDLE, clear rsp_valid, rsp_err and rdata to 0, and drive req_ready=0 while rst_n=0.
REQ-026 SHALL give reset priority over a pending ACCESS store, suppressing the write and discarding any RESP in progress.
REQ-027 SHALL NOT reset memory contents; only control and output registers reset.

Verification
REQ-028 SW 0xDEADBEEF @0x010, then LW @0x010 -> rdata=0xDEADBEEF, rsp_err=0, rsp_valid 2 cycles after each accept.
REQ-029 SB wdata=0x00000080 @0x013, then LB @0x013 -> 0xFFFFFF80; LBU @0x013 -> 0x00000080; LW @0x010 -> 0x80ADBEEF.
REQ-030 SH wdata=0x0000F234 @0x010, then LH @0x010 -> 0xFFFFF234; LHU @0x010 -> 0x0000F234; LW @0x010 -> 0x80ADF234.
REQ-031 LW @0x011 and SH @0x013 -> rsp_err=1, rdata=0; LW @0x010 afterwards still -> 0x80ADF234.
REQ-032 LW with rsp_ready low for 5 cycles -> rsp_valid, rdata and rsp_err constant, req_ready=0, and a concurrent req_valid is not accepted.
REQ-033 SW 0x11111111 @0x020 with rst_n=0 on the ACCESS edge -> all outputs 0, LW @0x020 after reset returns the prior contents, and req_ready=1 on the first cycle after rst_n rises.
